spi_display_ctrl: RTL and testbench
===================================

// Module: spi_display_ctrl
// PURPOSE
//  Command sequencer between the SPI slave byte interface and the 4-digit 7-seg driver.
//  - Parses opcode/argument bytes from the SPI receive strobe.
//  - Updates the digit0..3 and colon registers that feed the 7-seg driver.
//  - Loads a response byte with a one-cycle tx_ready strobe; that byte shifts out on the next SPI byte.
// PARAMETERS
//  TIMEOUT_CYCLES  1000000  clk cycles allowed between argument bytes (used only with CMD_TIMEOUT_EN)
//  ACK_BYTE        8'hA5    response to an accepted byte
//  NAK_BYTE        8'h5A    response to a rejected opcode/argument
// PORTS
//  clk        in   1  system clock (WF_CLK domain); single clock
//  reset      in   1  synchronous, active-high reset
//  cs_n       in   1  SPI frame select, already synchronised to clk; high = no frame
//  rx_valid   in   1  one-cycle strobe: rx_byte holds a complete received byte
//  rx_byte    in   8  received byte
//  tx_ready   out  1  one-cycle strobe: load tx_byte into the SPI slave
//  tx_byte    out  8  response byte; held between strobes
//  digit0..3  out  4  BCD digits (digit0 = LSD) to the 7-seg driver
//  colon      out  2  00 colon, 01 decimal point, 11 none
//  err_cnt    out  8  saturating count of rejected commands and aborts
// BEHAVIOUR
//  Reset values: state IDLE, tx_ready 0, tx_byte 8'h00, digits 0, colon 2'b11, err_cnt 0.
//  Latency: tx_ready pulses exactly 1 cycle after every rx_valid taken while cs_n = 0; never otherwise.
//  States: IDLE -> ARG1 -> (ARG2) -> IDLE.
//  Opcodes (taken in IDLE):
//   00      NOP        tx ACK, stay IDLE
//   1d      SET_DIGIT  d = 0..3; go ARG1; arg[3:0] <= 9 writes digit d and sends ACK; else NAK and err++
//   20      SET_COLON  go ARG1; arg[1:0] -> colon; ACK
//   30      SET_ALL    ARG1 = {d3,d2}, ARG2 = {d1,d0}, staged internally
//                      - all four digits commit in the same cycle, after ARG2 is received
//                      - any nibble > 9 rejects the whole command (NAK, err++); digits are left unchanged
//   40      READ       tx = {d3,d2} on the opcode; go ARG1; dummy arg returns tx = {d1,d0}
//   50      READ_ERR   tx = err_cnt; stay IDLE
//   other   tx NAK, err++, stay IDLE
//  Frame end: cs_n = 1 while in ARG1/ARG2 aborts the command.
//   - Return to IDLE, discard staged bytes, err++, no commit.
//   - cs_n = 1 while already in IDLE has no effect.
//  Simultaneous events:
//   - cs_n rising in the same cycle as rx_valid: frame end wins; the byte is dropped and no tx_ready fires.
//   - err++ from an abort and from a reject never occur in the same cycle; the counter saturates at 8'hFF.
//  Display outputs change only on a commit cycle; they are glitch-free with respect to scan_enable.
//  Reset mid-command: all state returns to reset values; staged arguments are lost.
// CONFIGURATION
//  Macro: CMD_TIMEOUT_EN
//   - Defined:
//     - A counter runs while in ARG1/ARG2 and clears on each rx_valid.
//     - At TIMEOUT_CYCLES it forces IDLE and increments err with no commit (same as a frame-end abort).
//     - tx_ready stays silent on timeout.
//   - Undefined: no counter; an ARG state waits indefinitely until a byte arrives or cs_n rises.
// STRUCTURE
//  Package spi_display_pkg:
//   - state enum {IDLE, ARG1, ARG2}
//   - opcode constants OP_NOP, OP_SET_DIGIT (upper nibble 1), OP_SET_COLON, OP_SET_ALL, OP_READ, OP_READ_ERR
//   - colon encodings COLON_ON, COLON_DP, COLON_OFF
//  Sub-module cmd_timeout: clearable counter with a terminal pulse; instantiated only under CMD_TIMEOUT_EN.
//  Everything else stays in one always block plus the output registers.
// TESTING
//  1. Reset, no stimulus -> digits 0, colon 11, tx_ready never high, err_cnt 0.
//  2. Frame 12,07 -> digit2 = 7; two tx_ready pulses, each 1 cycle after its rx_valid, tx = A5, A5.
//  3. Frame 30,98,76 -> digits {9,8,7,6} change in one cycle only after the 3rd byte.
//     Frame 30,9A,00 -> NAK, digits unchanged, err_cnt = 1.
//  4. Frame 30,12 then cs_n high -> no commit, err_cnt + 1.
//     cs_n rising with rx_valid in the same cycle -> no tx_ready.
//  5. Frame 40,00 with digits 1234 -> tx = 12 then 34.
//     Opcode FF -> NAK, then 50 returns the updated err_cnt.
//     Errors forced to 300 -> err_cnt holds at FF.
//  6. CMD_TIMEOUT_EN, TIMEOUT_CYCLES = 16: send 20, then idle 16 cycles -> state IDLE, err + 1, colon unchanged.
//     Next byte 00 is decoded as NOP.

Source files
------------

// File: rtl/spi_display_pkg.sv
// Shared types and constants for the SPI display command sequencer.
package spi_display_pkg;

    typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_t;

    // Command whose argument bytes are being collected.
    typedef enum logic [1:0] {CMD_DIGIT, CMD_COLON, CMD_ALL, CMD_READ} cmd_t;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_SET_DIGIT  = 8'h10;
    localparam logic [7:0] OP_DIGIT_MASK = 8'hFC;
    localparam logic [7:0] OP_SET_COLON  = 8'h20;
    localparam logic [7:0] OP_SET_ALL    = 8'h30;
    localparam logic [7:0] OP_READ       = 8'h40;
    localparam logic [7:0] OP_READ_ERR   = 8'h50;

    localparam logic [1:0] COLON_ON  = 2'b00;
    localparam logic [1:0] COLON_DP  = 2'b01;
    localparam logic [1:0] COLON_OFF = 2'b11;

    function automatic logic is_bcd(input logic [3:0] n);
        return n <= 4'd9;
    endfunction

endpackage

// File: rtl/spi_display_ctrl_cmd_timeout.sv
// cmd_timeout: clearable up-counter that pulses expire after LIMIT running cycles.
module cmd_timeout #(
    parameter int unsigned LIMIT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !run || clear) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    // A byte arriving on the terminal cycle still wins over the timeout.
    assign expire = run && !clear && (count == W'(LIMIT - 1));

endmodule

// File: rtl/spi_display_ctrl.sv
// spi_display_ctrl: parses SPI command bytes into digit/colon registers and loads responses.
// Optional argument timeout is built when CMD_TIMEOUT_EN is defined.
module spi_display_ctrl
    import spi_display_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5,
    parameter logic [7:0]  NAK_BYTE       = 8'h5A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [1:0] colon,
    output logic [7:0] err_cnt
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state, state_next;
    cmd_t             cmd, cmd_next;
    logic [1:0]       idx, idx_next;
    logic [7:0]       stage, stage_next;
    logic [3:0][3:0]  dig, dig_next;
    logic [1:0]       colon_next;
    logic [7:0]       err_next;
    logic             tx_ready_next;
    logic [7:0]       tx_byte_next;
    logic             expire;

`ifdef CMD_TIMEOUT_EN
    cmd_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .run    (state != IDLE),
        .clear  (rx_valid),
        .expire (expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        cmd_next      = cmd;
        idx_next      = idx;
        stage_next    = stage;
        dig_next      = dig;
        colon_next    = colon;
        err_next      = err_cnt;
        tx_ready_next = 1'b0;
        tx_byte_next  = tx_byte;

        if (cs_n) begin
            // Frame end drops any byte in the same cycle and aborts a pending command.
            if (state != IDLE) begin
                state_next = IDLE;
                err_next   = sat_inc(err_cnt);
            end
        end else if (rx_valid) begin
            tx_ready_next = 1'b1;
            tx_byte_next  = ACK_BYTE;
            unique case (state)
                IDLE: begin
                    case (rx_byte)
                        OP_NOP: ;
                        OP_SET_COLON: begin
                            cmd_next   = CMD_COLON;
                            state_next = ARG1;
                        end
                        OP_SET_ALL: begin
                            cmd_next   = CMD_ALL;
                            state_next = ARG1;
                        end
                        OP_READ: begin
                            tx_byte_next = {dig[3], dig[2]};
                            cmd_next     = CMD_READ;
                            state_next   = ARG1;
                        end
                        OP_READ_ERR: tx_byte_next = err_cnt;
                        default: begin
                            if ((rx_byte & OP_DIGIT_MASK) == OP_SET_DIGIT) begin
                                cmd_next   = CMD_DIGIT;
                                idx_next   = rx_byte[1:0];
                                state_next = ARG1;
                            end else begin
                                tx_byte_next = NAK_BYTE;
                                err_next     = sat_inc(err_cnt);
                            end
                        end
                    endcase
                end
                ARG1: begin
                    state_next = IDLE;
                    unique case (cmd)
                        CMD_DIGIT: begin
                            if (is_bcd(rx_byte[3:0])) begin
                                dig_next[idx] = rx_byte[3:0];
                            end else begin
                                tx_byte_next = NAK_BYTE;
                                err_next     = sat_inc(err_cnt);
                            end
                        end
                        CMD_COLON: colon_next = rx_byte[1:0];
                        CMD_ALL: begin
                            stage_next = rx_byte;
                            state_next = ARG2;
                        end
                        CMD_READ: tx_byte_next = {dig[1], dig[0]};
                    endcase
                end
                ARG2: begin
                    state_next = IDLE;
                    if (is_bcd(stage[7:4]) && is_bcd(stage[3:0]) &&
                        is_bcd(rx_byte[7:4]) && is_bcd(rx_byte[3:0])) begin
                        dig_next = {stage, rx_byte};
                    end else begin
                        tx_byte_next = NAK_BYTE;
                        err_next     = sat_inc(err_cnt);
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (expire) begin
            state_next = IDLE;
            err_next   = sat_inc(err_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cmd      <= CMD_DIGIT;
            idx      <= 2'd0;
            stage    <= 8'h00;
            dig      <= '0;
            colon    <= COLON_OFF;
            err_cnt  <= 8'h00;
            tx_ready <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            state    <= state_next;
            cmd      <= cmd_next;
            idx      <= idx_next;
            stage    <= stage_next;
            dig      <= dig_next;
            colon    <= colon_next;
            err_cnt  <= err_next;
            tx_ready <= tx_ready_next;
            tx_byte  <= tx_byte_next;
        end
    end

    assign digit0 = dig[0];
    assign digit1 = dig[1];
    assign digit2 = dig[2];
    assign digit3 = dig[3];

endmodule

// File: tb/tb_spi_display_ctrl.sv
// Directed and randomized bench for spi_display_ctrl against a command-level reference model.
module tb_spi_display_ctrl;

    localparam int unsigned TO  = 16;
    localparam logic [7:0]  ACK = 8'hA5;
    localparam logic [7:0]  NAK = 8'h5A;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs_n;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_ready;
    logic [7:0] tx_byte;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [1:0] colon;
    logic [7:0] err_cnt;

    int tests  = 0;
    int failed = 0;

    // Reference model: a command is the list of bytes collected so far.
    logic [3:0] m_dig [4];
    logic [1:0] m_colon;
    int         m_err;
    logic [7:0] q [$];

    spi_display_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .ACK_BYTE       (ACK),
        .NAK_BYTE       (NAK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cs_n     (cs_n),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .tx_ready (tx_ready),
        .tx_byte  (tx_byte),
        .digit0   (digit0),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .colon    (colon),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cmd_len(input logic [7:0] op);
        if (op == 8'h30) return 3;
        if (op == 8'h20 || op == 8'h40 || (op >= 8'h10 && op <= 8'h13)) return 2;
        return 1;
    endfunction

    function automatic logic bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
        m_colon = 2'b11;
        m_err   = 0;
        q.delete();
    endtask

    task automatic model_abort();
        if (q.size() > 0) begin
            bump_err();
            q.delete();
        end
    endtask

    task automatic model_take(input logic [7:0] b, output logic [7:0] rsp);
        logic [7:0] op;
        q.push_back(b);
        op  = q[0];
        rsp = ACK;
        if (q.size() == 1) begin
            if (op == 8'h40) rsp = {m_dig[3], m_dig[2]};
            else if (op == 8'h50) rsp = 8'(m_err);
            else if (!(op == 8'h00 || op == 8'h20 || op == 8'h30 || (op >= 8'h10 && op <= 8'h13))) begin
                rsp = NAK;
                bump_err();
            end
        end else if (op == 8'h20) begin
            m_colon = b[1:0];
        end else if (op == 8'h40) begin
            rsp = {m_dig[1], m_dig[0]};
        end else if (op == 8'h30) begin
            if (q.size() == 3) begin
                if (bcd_ok(q[1]) && bcd_ok(q[2])) begin
                    m_dig[3] = q[1][7:4];
                    m_dig[2] = q[1][3:0];
                    m_dig[1] = q[2][7:4];
                    m_dig[0] = q[2][3:0];
                end else begin
                    rsp = NAK;
                    bump_err();
                end
            end
        end else begin
            if (b[3:0] <= 4'd9) m_dig[op - 8'h10] = b[3:0];
            else begin
                rsp = NAK;
                bump_err();
            end
        end
        if (q.size() >= cmd_len(op)) q.delete();
    endtask

    task automatic check_display(input string tag);
        check({tag, " digit0"}, 32'(digit0), 32'(m_dig[0]));
        check({tag, " digit1"}, 32'(digit1), 32'(m_dig[1]));
        check({tag, " digit2"}, 32'(digit2), 32'(m_dig[2]));
        check({tag, " digit3"}, 32'(digit3), 32'(m_dig[3]));
        check({tag, " colon"},  32'(colon),  32'(m_colon));
        check({tag, " err_cnt"}, 32'(err_cnt), 32'(m_err));
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        logic [7:0] exp;
        @(negedge clk);
        cs_n     = 1'b0;
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        model_take(b, exp);
        check({tag, " tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, " tx_byte"},  32'(tx_byte),  32'(exp));
        check_display(tag);
        @(posedge clk);
        #1;
        check({tag, " tx_ready low"}, 32'(tx_ready), 32'd0);
    endtask

    task automatic end_frame(input string tag);
        @(negedge clk);
        cs_n = 1'b1;
        @(posedge clk);
        #1;
        model_abort();
        check({tag, " tx_ready"}, 32'(tx_ready), 32'd0);
        check_display(tag);
    endtask

    task automatic collide(input logic [7:0] b, input string tag);
        @(negedge clk);
        cs_n     = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        model_abort();
        check({tag, " tx_ready"}, 32'(tx_ready), 32'd0);
        check_display(tag);
        @(posedge clk);
        #1;
        check({tag, " tx_ready next"}, 32'(tx_ready), 32'd0);
    endtask

    initial begin
        logic [7:0] ops [10];
        ops = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h30, 8'h40, 8'h50, 8'hFF};

        reset    = 1'b1;
        cs_n     = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state and quiet bus
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("reset tx_ready", 32'(tx_ready), 32'd0);
        end
        check("reset tx_byte", 32'(tx_byte), 32'h00);
        check_display("reset");

        // Single digit write
        send_byte(8'h12, "digit op");
        send_byte(8'h07, "digit arg");
        end_frame("digit end");

        // Atomic four-digit write, then a rejected one
        send_byte(8'h30, "all op");
        send_byte(8'h98, "all a1");
        send_byte(8'h76, "all a2");
        end_frame("all end");
        send_byte(8'h30, "allbad op");
        send_byte(8'h9A, "allbad a1");
        send_byte(8'h00, "allbad a2");
        end_frame("allbad end");

        // Aborts
        send_byte(8'h30, "abort op");
        send_byte(8'h12, "abort a1");
        end_frame("abort end");
        send_byte(8'h20, "coll op");
        collide(8'h01, "coll arg");
        collide(8'h00, "coll idle");

        // Read back, bad opcode, error readout and saturation
        send_byte(8'h30, "rd set");
        send_byte(8'h12, "rd s1");
        send_byte(8'h34, "rd s2");
        send_byte(8'h40, "read op");
        send_byte(8'h00, "read arg");
        send_byte(8'hFF, "bad op");
        send_byte(8'h50, "read err");
        for (int i = 0; i < 300; i++) send_byte(8'hFF, "sat");
        send_byte(8'h50, "read err sat");
        check("sat err_cnt", 32'(err_cnt), 32'hFF);

        // Reset in the middle of a command
        send_byte(8'h30, "mid op");
        send_byte(8'h55, "mid a1");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("mid tx_ready", 32'(tx_ready), 32'd0);
        check_display("mid reset");
        send_byte(8'h00, "mid nop");

`ifdef CMD_TIMEOUT_EN
        send_byte(8'h20, "to op");
        repeat (14) @(posedge clk);
        #1;
        check("to before", 32'(err_cnt), 32'(m_err));
        @(posedge clk);
        #1;
        model_abort();
        check("to tx_ready", 32'(tx_ready), 32'd0);
        check_display("to fire");
        send_byte(8'h00, "to nop");
`endif

        // Randomized command traffic
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            logic [7:0]  b;
            r = $urandom_range(0, 19);
            if (r < 2) begin
                end_frame("rand end");
            end else if (r == 2) begin
                collide(8'($urandom), "rand coll");
            end else begin
                if (q.size() == 0) begin
                    b = (r == 3) ? 8'($urandom) : ops[$urandom_range(0, 9)];
                end else if ($urandom_range(0, 3) == 0) begin
                    b = 8'($urandom);
                end else begin
                    b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                end
                send_byte(b, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
